// File: rtl/regfile_pkg.sv
// Shared register-file types for the writeback arbiter and its users.
package regfile_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned REG_DW = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin arbiter: one-hot grant starting the search at ptr, ptr moves past
// the winner only when the caller reports the grant was consumed (advance).
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] nxt_ptr;
  logic          found;
  int unsigned   idx;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    grant   = '0;
    nxt_ptr = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        nxt_ptr    = (idx + 1 == N) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = nxt_ptr;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among N_REQ writeback sources and tracks
// pending destinations for RAW stalls. Define REGARB_STATS_EN for grant/conflict counters.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned AW    = REG_AW,
  parameter int unsigned DW    = REG_DW,
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*AW-1:0]   req_addr,
  input  logic [N_REQ*DW-1:0]   req_data,
  output logic                  rf_wr_en,
  output logic [AW-1:0]         rf_wr_addr,
  output logic [DW-1:0]         rf_wr_data,
  input  logic                  sb_set_en,
  input  logic [AW-1:0]         sb_set_addr,
`ifdef REGARB_STATS_EN
  output logic [N_REQ*CNT_W-1:0] stat_grant,
  output logic [CNT_W-1:0]       stat_confl,
`endif
  output logic [2**AW-1:0]      sb_pending
);

  localparam int unsigned NREG = 2**AW;
  localparam int unsigned PW   = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || CNT_W == 0) begin : g_bad_cfg
    $error("regfile_wb_arbiter: N_REQ must be 2..8 and CNT_W nonzero");
  end

  logic [N_REQ-1:0] grant;
  logic [PW-1:0]    unused_rr_ptr;
  logic             xfer;
  logic             issue;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;

  logic            rf_wr_en_q,   rf_wr_en_d;
  logic [AW-1:0]   rf_wr_addr_q, rf_wr_addr_d;
  logic [DW-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic [NREG-1:0] sb_q,         sb_d;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (xfer),
    .grant   (grant),
    .ptr     (unused_rr_ptr)
  );

  assign req_ready = rst ? '0 : grant;
  assign xfer      = |req_ready;

  // Grant is one-hot, so an OR-style select picks the winner's payload.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Writes to register 0 are swallowed: handshake completes but nothing issues.
  assign issue = xfer && (sel_addr != '0);

  always_comb begin
    rf_wr_en_d   = issue;
    rf_wr_addr_d = issue ? sel_addr : rf_wr_addr_q;
    rf_wr_data_d = issue ? sel_data : rf_wr_data_q;
    sb_d         = sb_q;
    if (issue) sb_d[sel_addr] = 1'b0;
    // A same-cycle set overrides the clear: it belongs to a newer producer.
    if (sb_set_en && sb_set_addr != '0) sb_d[sb_set_addr] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
      sb_q         <= '0;
    end else begin
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      sb_q         <= sb_d;
    end
  end

  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign sb_pending = sb_q;

`ifdef REGARB_STATS_EN
  logic [N_REQ*CNT_W-1:0] stat_grant_q, stat_grant_d;
  logic [CNT_W-1:0]       stat_confl_q, stat_confl_d;
  int unsigned            n_valid;

  always_comb begin
    stat_grant_d = stat_grant_q;
    stat_confl_d = stat_confl_q;
    n_valid      = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_valid[i]) n_valid = n_valid + 1;
      if (req_ready[i])
        stat_grant_d[i*CNT_W +: CNT_W] = stat_grant_q[i*CNT_W +: CNT_W] + CNT_W'(1);
    end
    if (n_valid >= 2) stat_confl_d = stat_confl_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grant_q <= '0;
      stat_confl_q <= '0;
    end else begin
      stat_grant_q <= stat_grant_d;
      stat_confl_q <= stat_confl_d;
    end
  end

  assign stat_grant = stat_grant_q;
  assign stat_confl = stat_confl_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter (N_REQ=2); stats checks when REGARB_STATS_EN is defined.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int unsigned N_REQ = 2;
  localparam int unsigned AW    = REG_AW;
  localparam int unsigned DW    = REG_DW;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned NREG  = 2**AW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*AW-1:0]  req_addr;
  logic [N_REQ*DW-1:0]  req_data;
  logic                 rf_wr_en;
  logic [AW-1:0]        rf_wr_addr;
  logic [DW-1:0]        rf_wr_data;
  logic                 sb_set_en;
  logic [AW-1:0]        sb_set_addr;
  logic [NREG-1:0]      sb_pending;
`ifdef REGARB_STATS_EN
  logic [N_REQ*CNT_W-1:0] stat_grant;
  logic [CNT_W-1:0]       stat_confl;
`endif

  regfile_wb_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
`ifdef REGARB_STATS_EN
    .stat_grant  (stat_grant),
    .stat_confl  (stat_confl),
`endif
    .sb_pending  (sb_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            en;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [NREG-1:0] sb;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state (value after the upcoming edge)
  int               mdl_ptr;
  logic [AW-1:0]    mdl_addr;
  logic [DW-1:0]    mdl_data;
  logic [NREG-1:0]  mdl_sb;
  logic [N_REQ-1:0] exp_ready;
  int               mdl_gcnt[N_REQ];
  int               mdl_confl;

  // Apply one cycle of stimulus, predict ready now and outputs after the edge.
  task automatic drive(input logic r, input logic [N_REQ-1:0] v, input wb_req_t q0,
                       input wb_req_t q1, input logic se, input logic [AW-1:0] sa);
    int        g;
    logic      en;
    reg_addr_t a;
    reg_data_t d;
    rst         = r;
    req_valid   = v;
    req_addr    = {q1.addr, q0.addr};
    req_data    = {q1.data, q0.data};
    sb_set_en   = se;
    sb_set_addr = sa;
    exp_ready   = '0;
    en          = 1'b0;
    if (r) begin
      mdl_ptr  = 0;
      mdl_addr = '0;
      mdl_data = '0;
      mdl_sb   = '0;
      mdl_confl = 0;
      for (int i = 0; i < N_REQ; i++) mdl_gcnt[i] = 0;
    end else begin
      g = -1;
      for (int k = 0; k < N_REQ; k++) begin
        if (g < 0 && v[(mdl_ptr + k) % N_REQ]) g = (mdl_ptr + k) % N_REQ;
      end
      if (v == 2'b11) mdl_confl++;
      if (g >= 0) begin
        exp_ready[g] = 1'b1;
        mdl_ptr      = (g + 1) % N_REQ;
        mdl_gcnt[g]++;
        a = (g == 0) ? q0.addr : q1.addr;
        d = (g == 0) ? q0.data : q1.data;
        if (a != '0) begin
          en         = 1'b1;
          mdl_addr   = a;
          mdl_data   = d;
          mdl_sb[a]  = 1'b0;
        end
      end
      if (se && sa != '0) mdl_sb[sa] = 1'b1;
    end
    exp_q.push_back('{en: en, addr: mdl_addr, data: mdl_data, sb: mdl_sb});
  endtask

  task automatic test_reset();
    exp_t e, o;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b11, '{addr: 5'd4, data: 32'h1111_1111},
            '{addr: 5'd6, data: 32'h2222_2222}, 1'b1, 5'd3);
      #1;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL reset_ready step %0d: got %b want %b", i, req_ready, exp_ready);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = {rf_wr_en, rf_wr_addr, rf_wr_data, sb_pending};
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL reset_out step %0d: got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_single();
    exp_t e, o;
    for (int i = 0; i < 2; i++) begin
      if (i == 0)
        drive(1'b0, 2'b01, '{addr: 5'd5, data: 32'hDEAD_BEEF}, '{addr: 5'd0, data: 32'h0}, 1'b0, 5'd0);
      else
        drive(1'b0, 2'b00, '{addr: 5'd9, data: 32'h1234_5678}, '{addr: 5'd0, data: 32'h0}, 1'b0, 5'd0);
      #1;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL single_ready step %0d: got %b want %b", i, req_ready, exp_ready);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = {rf_wr_en, rf_wr_addr, rf_wr_data, sb_pending};
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL single_out step %0d: got %h want %h", i, o, e);
      end
      checks++;
      if (rf_wr_addr !== 5'd5 || rf_wr_data !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL single_hold step %0d: got %0d/%h want 5/deadbeef", i, rf_wr_addr, rf_wr_data);
      end
    end
  endtask

  task automatic test_round_robin();
    exp_t e, o;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 2'b11, '{addr: AW'(10 + i), data: 32'hA000_0000 + 32'(i)},
            '{addr: AW'(20 + i), data: 32'hB000_0000 + 32'(i)}, 1'b0, 5'd0);
      #1;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL rr_ready step %0d: got %b want %b", i, req_ready, exp_ready);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = {rf_wr_en, rf_wr_addr, rf_wr_data, sb_pending};
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL rr_out step %0d: got %h want %h", i, o, e);
      end
    end
`ifdef REGARB_STATS_EN
    checks++;
    if (stat_grant !== {CNT_W'(mdl_gcnt[1]), CNT_W'(mdl_gcnt[0])}) begin
      errors++; $display("FAIL stat_grant: got %h want %0d/%0d", stat_grant, mdl_gcnt[1], mdl_gcnt[0]);
    end
    checks++;
    if (stat_confl !== CNT_W'(mdl_confl)) begin
      errors++; $display("FAIL stat_confl: got %0d want %0d", stat_confl, mdl_confl);
    end
`endif
  endtask

  task automatic test_reg0();
    exp_t e, o;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive(1'b0, 2'b00, '{addr: 5'd0, data: 32'h0}, '{addr: 5'd0, data: 32'h0}, 1'b1, 5'd1);
        1: drive(1'b0, 2'b10, '{addr: 5'd0, data: 32'h0}, '{addr: 5'd0, data: 32'hCAFE_F00D}, 1'b1, 5'd0);
        default: drive(1'b0, 2'b10, '{addr: 5'd0, data: 32'h0}, '{addr: 5'd0, data: 32'h5555_AAAA}, 1'b0, 5'd0);
      endcase
      #1;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL reg0_ready step %0d: got %b want %b", i, req_ready, exp_ready);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = {rf_wr_en, rf_wr_addr, rf_wr_data, sb_pending};
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL reg0_out step %0d: got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_scoreboard();
    exp_t e, o;
    logic exp7[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive(1'b0, 2'b00, '{addr: 5'd0, data: 32'h0}, '{addr: 5'd0, data: 32'h0}, 1'b1, 5'd7);
        1: drive(1'b0, 2'b00, '{addr: 5'd0, data: 32'h0}, '{addr: 5'd0, data: 32'h0}, 1'b0, 5'd0);
        2: drive(1'b0, 2'b01, '{addr: 5'd7, data: 32'h7777_0001}, '{addr: 5'd0, data: 32'h0}, 1'b0, 5'd0);
        3: drive(1'b0, 2'b00, '{addr: 5'd0, data: 32'h0}, '{addr: 5'd0, data: 32'h0}, 1'b1, 5'd7);
        4: drive(1'b0, 2'b10, '{addr: 5'd0, data: 32'h0}, '{addr: 5'd7, data: 32'h7777_0002}, 1'b1, 5'd7);
        default: drive(1'b0, 2'b00, '{addr: 5'd0, data: 32'h0}, '{addr: 5'd0, data: 32'h0}, 1'b1, 5'd7);
      endcase
      #1;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL sb_ready step %0d: got %b want %b", i, req_ready, exp_ready);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = {rf_wr_en, rf_wr_addr, rf_wr_data, sb_pending};
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL sb_out step %0d: got %h want %h", i, o, e);
      end
      checks++;
      if (sb_pending[7] !== exp7[i]) begin
        errors++; $display("FAIL sb_bit7 step %0d: got %b want %b", i, sb_pending[7], exp7[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, o;
    logic [1:0] fixed_ready[5] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b10};
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(1'b0, 2'b00, '{addr: 5'd0, data: 32'h0}, '{addr: 5'd0, data: 32'h0}, 1'b1, 5'd3);
        1: drive(1'b0, 2'b11, '{addr: 5'd12, data: 32'hC0C0_0012}, '{addr: 5'd13, data: 32'hC0C0_0013}, 1'b1, 5'd9);
        2: drive(1'b1, 2'b11, '{addr: 5'd12, data: 32'h0}, '{addr: 5'd13, data: 32'h0}, 1'b1, 5'd5);
        default: drive(1'b0, 2'b11, '{addr: AW'(14 + i), data: 32'hD000_0000 + 32'(i)},
                       '{addr: AW'(24 + i), data: 32'hE000_0000 + 32'(i)}, 1'b0, 5'd0);
      endcase
      #1;
      checks++;
      if (req_ready !== exp_ready || (i != 1 && req_ready !== fixed_ready[i])) begin
        errors++; $display("FAIL rmid_ready step %0d: got %b want %b", i, req_ready, exp_ready);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = {rf_wr_en, rf_wr_addr, rf_wr_data, sb_pending};
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL rmid_out step %0d: got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, N_REQ'($urandom_range(3, 0)),
            '{addr: AW'($urandom_range(31, 0)), data: 32'($urandom)},
            '{addr: AW'($urandom_range(31, 0)), data: 32'($urandom)},
            1'($urandom_range(1, 0)), AW'($urandom_range(31, 0)));
      #1;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL b2b_ready step %0d: got %b want %b", i, req_ready, exp_ready);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = {rf_wr_en, rf_wr_addr, rf_wr_data, sb_pending};
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL b2b_out step %0d: got %h want %h", i, o, e);
      end
    end
`ifdef REGARB_STATS_EN
    checks++;
    if (stat_confl !== CNT_W'(mdl_confl)) begin
      errors++; $display("FAIL b2b_stat_confl: got %0d want %0d", stat_confl, mdl_confl);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_reg0();
    test_scoreboard();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL queue_drain: got %0d entries want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
